// File: rtl/pipo_load_arbiter_pkg.sv
// pipo_load_arbiter_pkg: shared FSM state encoding and owner-index width helper
package pipo_load_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
  function automatic int owner_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pipo_load_arbiter_if.sv
// pipo_load_arbiter_if: requester-side bus (clr, req, p_data) and register-side results (gnt, q, q_owner, q_valid, busy)
interface pipo_load_arbiter_if import pipo_load_arbiter_pkg::*; #(
  parameter int N = 8,
  parameter int NREQ = 4
) ();
  localparam int OW = owner_w(NREQ);
  logic clr;
  logic [NREQ-1:0] req;
  logic [NREQ*N-1:0] p_data;
  logic [NREQ-1:0] gnt;
  logic [N-1:0] q;
  logic [OW-1:0] q_owner;
  logic q_valid;
  logic busy;
  modport master (output clr, req, p_data, input gnt, q, q_owner, q_valid, busy);
  modport slave (input clr, req, p_data, output gnt, q, q_owner, q_valid, busy);
endinterface

// File: rtl/pipo_rr_picker.sv
// pipo_rr_picker: combinational round-robin one-hot pick of req starting at ptr (gnt) plus binary winner index (idx)
module pipo_rr_picker import pipo_load_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  parameter int OW = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [OW-1:0]   idx
);
  logic hit;
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit && req[(int'(ptr) + k) % NREQ]) begin
        hit = 1'b1;
        gnt[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = OW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter: round-robin shared PIPO register with post-load hold window (clk, active-low sync rst, bus slave)
module pipo_load_arbiter import pipo_load_arbiter_pkg::*; #(
  parameter int N = 8,
  parameter int NREQ = 4,
  parameter int HOLD = 2
) (
  input logic clk,
  input logic rst,
  pipo_load_arbiter_if.slave bus
);
  localparam int OW = owner_w(NREQ);
  localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
  state_t state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] win;
  logic [CW-1:0] cnt;
  logic [NREQ-1:0] pick;
  pipo_rr_picker #(.NREQ(NREQ), .OW(OW)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .gnt(pick),
    .idx(win)
  );
  assign bus.gnt = (rst && !bus.clr && state == ST_IDLE) ? pick : '0;
  assign bus.busy = rst && state == ST_HOLD;
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.q <= '0;
      bus.q_owner <= '0;
      bus.q_valid <= 1'b0;
      state <= ST_IDLE;
      cnt <= '0;
      ptr <= '0;
    end else if (bus.clr) begin
      bus.q <= '0;
      bus.q_valid <= 1'b0;
      state <= ST_IDLE;
      cnt <= '0;
    end else if (state == ST_HOLD) begin
      cnt <= cnt == '0 ? '0 : cnt - CW'(1);
      state <= cnt == '0 ? ST_IDLE : ST_HOLD;
    end else if (|bus.req) begin
      bus.q <= bus.p_data[win*N +: N];
      bus.q_owner <= win;
      bus.q_valid <= 1'b1;
      ptr <= win == OW'(NREQ-1) ? '0 : win + OW'(1);
      state <= HOLD > 0 ? ST_HOLD : ST_IDLE;
      cnt <= HOLD > 0 ? CW'(HOLD-1) : '0;
    end
  end
endmodule
